// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-Wire master: FSM states, register map,
// bit positions and all bus timing in microseconds.
package onewire_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_LOW,
    ST_RST_SAMPLE,
    ST_RST_REC,
    ST_SLOT_LOW,
    ST_SLOT_HIGH,
    ST_SLOT_REC
  } ow_state_e;

  typedef enum logic [1:0] {
    OP_RESET,
    OP_WRITE,
    OP_READ
  } ow_op_e;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;

  localparam int CTRL_START_RST = 0;
  localparam int CTRL_START_WR  = 1;
  localparam int CTRL_START_RD  = 2;
  localparam int CTRL_IRQ_EN    = 3;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_PRESENCE = 1;
  localparam int STAT_DONE     = 2;

  localparam int US_W = 9;

  localparam logic [US_W-1:0] T_RST_LOW    = 9'd480;
  localparam logic [US_W-1:0] T_RST_SAMPLE = 9'd70;
  localparam logic [US_W-1:0] T_RST_REC    = 9'd410;
  localparam logic [US_W-1:0] T_W1_LOW     = 9'd6;
  localparam logic [US_W-1:0] T_W1_REL     = 9'd64;
  localparam logic [US_W-1:0] T_W0_LOW     = 9'd60;
  localparam logic [US_W-1:0] T_W0_REL     = 9'd10;
  localparam logic [US_W-1:0] T_RD_LOW     = 9'd6;
  localparam logic [US_W-1:0] T_RD_SAMPLE  = 9'd15;
  localparam logic [US_W-1:0] T_SLOT       = 9'd70;
  localparam logic [US_W-1:0] T_SLOT_REC   = 9'd1;

  function automatic logic [US_W-1:0] slot_low_us(input ow_op_e op, input logic bit_val);
    if (op == OP_READ) return T_RD_LOW;
    return bit_val ? T_W1_LOW : T_W0_LOW;
  endfunction

  function automatic logic [US_W-1:0] slot_rel_us(input ow_op_e op, input logic bit_val);
    if (op == OP_READ) return T_SLOT - T_RD_LOW;
    return bit_val ? T_W1_REL : T_W0_REL;
  endfunction

endpackage

// File: rtl/onewire_us_tick.sv
// Free-running prescaler producing a one-cycle pulse once per microsecond.
module onewire_us_tick #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned DIV = (CLK_HZ / 1000000 < 1) ? 1 : CLK_HZ / 1000000;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CNT_W'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/onewire_master.sv
// Register-mapped 1-Wire bus master: reset/presence, byte write and byte read,
// open-drain line with a synchronized sample path.
module onewire_master
  import onewire_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  inout  wire         bidir_port
);

  localparam logic [US_W-1:0] RD_SAMPLE_OFS = T_RD_SAMPLE - T_RD_LOW - 9'd1;

  ow_state_e       state_q, state_d;
  ow_op_e          op_q, start_op;
  logic [US_W-1:0] us_cnt, phase_us;
  logic [2:0]      bit_cnt;
  logic [7:0]      tx_byte, rx_byte;
  logic            irq_en, busy, done, presence;
  logic [1:0]      line_sync;
  logic            line_s, tick, cur_bit;
  logic            drive_low, phase_end, finish, sample_pres, sample_rx;
  logic            wr_stb, wr_data, wr_ctrl, wr_stat, start_acc;
  logic [31:0]     status_word;
  logic            unused_wdata;

  onewire_us_tick #(.CLK_HZ(CLK_HZ)) u_us_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign wr_stb  = chipselect && !write_n;
  assign wr_data = wr_stb && (address == ADDR_DATA);
  assign wr_ctrl = wr_stb && (address == ADDR_CONTROL);
  assign wr_stat = wr_stb && (address == ADDR_STATUS);

  assign start_acc = wr_ctrl && !busy &&
                     (writedata[CTRL_START_RST] || writedata[CTRL_START_WR] ||
                      writedata[CTRL_START_RD]);

  always_comb begin
    start_op = OP_READ;
    if (writedata[CTRL_START_RST])     start_op = OP_RESET;
    else if (writedata[CTRL_START_WR]) start_op = OP_WRITE;
  end

  assign unused_wdata = ^writedata[31:8];
  assign line_s       = line_sync[1];
  assign cur_bit      = tx_byte[bit_cnt];

  // Phase length of the current state, then next-state selection.
  always_comb begin
    phase_us = T_SLOT_REC;
    case (state_q)
      ST_RST_LOW:    phase_us = T_RST_LOW;
      ST_RST_SAMPLE: phase_us = T_RST_SAMPLE;
      ST_RST_REC:    phase_us = T_RST_REC;
      ST_SLOT_LOW:   phase_us = slot_low_us(op_q, cur_bit);
      ST_SLOT_HIGH:  phase_us = slot_rel_us(op_q, cur_bit);
      default:       phase_us = T_SLOT_REC;
    endcase

    phase_end = tick && (state_q != ST_IDLE) && (us_cnt == phase_us - 1'b1);

    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (start_acc) state_d = (start_op == OP_RESET) ? ST_RST_LOW : ST_SLOT_LOW;
      ST_RST_LOW:    if (phase_end) state_d = ST_RST_SAMPLE;
      ST_RST_SAMPLE: if (phase_end) state_d = ST_RST_REC;
      ST_RST_REC:    if (phase_end) state_d = ST_IDLE;
      ST_SLOT_LOW:   if (phase_end) state_d = ST_SLOT_HIGH;
      ST_SLOT_HIGH:  if (phase_end) state_d = ST_SLOT_REC;
      ST_SLOT_REC:
        if (phase_end) state_d = (bit_cnt == 3'd7) ? ST_IDLE : ST_SLOT_LOW;
      default:       state_d = ST_IDLE;
    endcase

    drive_low   = (state_q == ST_RST_LOW) || (state_q == ST_SLOT_LOW);
    finish      = phase_end && ((state_q == ST_RST_REC) ||
                                ((state_q == ST_SLOT_REC) && (bit_cnt == 3'd7)));
    sample_pres = phase_end && (state_q == ST_RST_SAMPLE);
    sample_rx   = tick && (state_q == ST_SLOT_HIGH) && (op_q == OP_READ) &&
                  (us_cnt == RD_SAMPLE_OFS);
  end

  // Open-drain: only ever pull low; async reset releases the line at once.
  assign bidir_port = drive_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_RESET;
      us_cnt  <= '0;
      bit_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) op_q <= start_op;
      if (start_acc || phase_end) us_cnt <= '0;
      else if (tick && (state_q != ST_IDLE)) us_cnt <= us_cnt + 1'b1;
      if (start_acc) bit_cnt <= '0;
      else if (phase_end && (state_q == ST_SLOT_REC)) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_sync <= 2'b11;
    end else begin
      line_sync <= {line_sync[0], bidir_port};
    end
  end

  // Done set on completion outranks a software clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      presence <= 1'b0;
      irq_en   <= 1'b0;
      tx_byte  <= '0;
      rx_byte  <= '0;
    end else begin
      if (start_acc)   busy <= 1'b1;
      else if (finish) busy <= 1'b0;

      if (finish)                             done <= 1'b1;
      else if (start_acc)                     done <= 1'b0;
      else if (wr_stat && writedata[STAT_DONE]) done <= 1'b0;

      if (sample_pres) presence <= !line_s;
      if (wr_ctrl)     irq_en   <= writedata[CTRL_IRQ_EN];
      if (wr_data && !busy) tx_byte <= writedata[7:0];
      if (sample_rx)   rx_byte[bit_cnt] <= line_s;
    end
  end

  always_comb begin
    status_word                = '0;
    status_word[STAT_BUSY]     = busy;
    status_word[STAT_PRESENCE] = presence;
    status_word[STAT_DONE]     = done;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        ADDR_DATA:    readdata <= {24'b0, rx_byte};
        ADDR_CONTROL: readdata <= {31'b0, irq_en};
        ADDR_STATUS:  readdata <= status_word;
        default:      readdata <= '0;
      endcase
    end
  end

  assign irq = done && irq_en;

endmodule

// File: tb/tb_onewire_master.sv
// Directed bench for onewire_master at 10 MHz (10 cycles per microsecond)
// with a small 1-Wire slave model on a pulled-up line.
module tb_onewire_master;
  import onewire_pkg::*;

  localparam int unsigned CLK_HZ = 10000000;
  localparam int CPU = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  wire         owire;
  logic        slave_low = 1'b0;

  pullup (owire);
  assign owire = slave_low ? 1'b0 : 1'bz;

  onewire_master #(.CLK_HZ(CLK_HZ)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .bidir_port (owire)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Low-pulse recorder: lengths in cycles of every low run on the line.
  int run_len = 0;
  int pulse_idx = 0;
  int pulse_len [64];

  always @(negedge clk) begin
    if (owire === 1'b0) run_len <= run_len + 1;
    else if (run_len != 0) begin
      pulse_len[pulse_idx % 64] <= run_len;
      pulse_idx <= pulse_idx + 1;
      run_len <= 0;
    end
  end

  // Slave: mode 1 answers a reset pulse with presence 20..140 us after release,
  // mode 2 returns slave_byte LSB first by holding 0-bits low for 30 us.
  int         slave_mode = 0;
  logic [7:0] slave_byte = 8'h00;
  logic [2:0] slv_bit = 3'd0;
  logic       mlow;
  logic       mlow_q = 1'b0;
  int         low_cnt = 0;
  int         pres_delay = 0;
  int         slv_timer = 0;

  assign mlow = (owire === 1'b0) && !slave_low;

  always @(posedge clk) begin
    mlow_q <= mlow;
    if (mlow) low_cnt <= low_cnt + 1;
    if (slave_mode != 2) slv_bit <= 3'd0;
    if (mlow && !mlow_q) begin
      low_cnt <= 1;
      if (slave_mode == 2) begin
        slv_bit <= slv_bit + 3'd1;
        if (!slave_byte[slv_bit]) begin
          slave_low <= 1'b1;
          slv_timer <= 30 * CPU;
        end
      end
    end
    if (!mlow && mlow_q && slave_mode == 1 && low_cnt > 400 * CPU) pres_delay <= 20 * CPU;
    if (pres_delay > 0) begin
      if (pres_delay == 1) begin
        slave_low <= 1'b1;
        slv_timer <= 120 * CPU;
      end
      pres_delay <= pres_delay - 1;
    end
    if (slv_timer > 0) begin
      if (slv_timer == 1) slave_low <= 1'b0;
      slv_timer <= slv_timer - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    address = ADDR_STATUS;
    cyc = 0;
    repeat (3) begin @(negedge clk); cyc++; end
    while (readdata[STAT_DONE] !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_slots(input string tag, input int base, input int exp_us [8]);
    for (int k = 0; k < 8; k++)
      check_range($sformatf("%s_slot%0d", tag, k), pulse_len[(base + k) % 64],
                  (exp_us[k] - 1) * CPU, (exp_us[k] + 1) * CPU);
  endtask

  initial begin
    logic [31:0] rd;
    int cyc;
    int base;
    int a5_us [8];
    int x5a_us [8];
    a5_us  = '{6, 60, 6, 60, 60, 6, 60, 6};
    x5a_us = '{60, 6, 60, 6, 6, 60, 6, 60};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_line", {31'b0, owire}, 32'h1);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(ADDR_STATUS, rd);  check("rst_status", rd, 32'h0);
    bus_read(ADDR_DATA, rd);    check("rst_data", rd, 32'h0);
    bus_read(ADDR_CONTROL, rd); check("rst_control", rd, 32'h0);
    bus_read(3'd5, rd);         check("unmapped_read", rd, 32'h0);

    // Reset with a responding slave
    slave_mode = 1;
    base = pulse_idx;
    bus_write(ADDR_CONTROL, 32'h9);
    bus_read(ADDR_STATUS, rd); check("rst_op_busy", rd, 32'h1);
    wait_done(12000, cyc);
    check_range("rst_op_cycles", cyc, 1, 11999);
    check_range("rst_low_cycles", pulse_len[base % 64], 479 * CPU, 481 * CPU);
    check("rst_op_pulses", 32'(pulse_idx - base), 32'd2);
    bus_read(ADDR_STATUS, rd); check("rst_op_status", rd, 32'h6);
    check("rst_op_irq", {31'b0, irq}, 32'h1);
    bus_read(ADDR_CONTROL, rd); check("irq_en_readback", rd, 32'h1);

    // Reset with no slave: full 960 us and no presence
    slave_mode = 0;
    bus_write(ADDR_CONTROL, 32'h9);
    wait_done(12000, cyc);
    check_range("noslave_duration", cyc, 957 * CPU, 962 * CPU);
    bus_read(ADDR_STATUS, rd); check("noslave_status", rd, 32'h4);

    // Write byte 0xA5
    bus_write(ADDR_DATA, 32'hA5);
    base = pulse_idx;
    bus_write(ADDR_CONTROL, 32'hA);
    wait_done(7000, cyc);
    check_range("wr_done_cycles", cyc, 1, 6999);
    check("wr_pulses", 32'(pulse_idx - base), 32'd8);
    check_slots("wrA5", base, a5_us);
    bus_read(ADDR_DATA, rd); check("wr_rx_untouched", rd, 32'h0);

    // Read byte, slave returns 0x3C
    slave_byte = 8'h3C;
    slave_mode = 2;
    bus_write(ADDR_CONTROL, 32'hC);
    wait_done(7000, cyc);
    check_range("rd_done_cycles", cyc, 1, 6999);
    slave_mode = 0;
    bus_read(ADDR_DATA, rd);   check("rd_data", rd, 32'h3C);
    bus_read(ADDR_STATUS, rd); check("rd_status", rd, 32'h4);

    // Writes while busy are ignored; a done-clear racing completion loses
    bus_write(ADDR_DATA, 32'h5A);
    base = pulse_idx;
    bus_write(ADDR_CONTROL, 32'hA);
    repeat (100) @(negedge clk);
    bus_write(ADDR_DATA, 32'hFF);
    bus_write(ADDR_CONTROL, 32'h9);
    @(negedge clk);
    address = ADDR_STATUS; writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0;
    cyc = 0;
    while (irq !== 1'b1 && cyc < 7000) begin
      @(negedge clk);
      cyc++;
    end
    chipselect = 1'b0; write_n = 1'b1;
    check_range("race_done_seen", cyc, 1, 6999);
    repeat (3) @(negedge clk);
    check("race_irq_held", {31'b0, irq}, 32'h1);
    bus_read(ADDR_STATUS, rd); check("race_status", rd, 32'h4);
    check("busy_pulses", 32'(pulse_idx - base), 32'd8);
    check_slots("busy5A", base, x5a_us);
    bus_read(ADDR_DATA, rd); check("busy_rx_untouched", rd, 32'h3C);

    // Async reset during a slot low phase
    bus_write(ADDR_DATA, 32'hFF);
    bus_write(ADDR_CONTROL, 32'hA);
    cyc = 0;
    while (owire !== 1'b0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    repeat (20) @(negedge clk);
    check("slot_line_driven", {31'b0, owire}, 32'h0);
    #1 reset_n = 1'b0;
    #1;
    check("areset_line_released", {31'b0, owire}, 32'h1);
    check("areset_readdata", readdata, 32'h0);
    check("areset_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(ADDR_STATUS, rd);  check("areset_status", rd, 32'h0);
    bus_read(ADDR_CONTROL, rd); check("areset_control", rd, 32'h0);
    bus_read(ADDR_DATA, rd);    check("areset_rx", rd, 32'h0);
    base = pulse_idx;
    bus_write(ADDR_CONTROL, 32'h2);
    wait_done(7000, cyc);
    check_range("areset_tx_cleared", pulse_len[base % 64], 59 * CPU, 61 * CPU);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
